uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter, successor to the fixed 8N1 transmitter.
- Buffers bus-side words in an internal FIFO.
- Serialises each word as start, DATA_WIDTH data bits (LSB first), optional parity, then 1 or 2 stop bits.
- Bit period comes from a runtime divisor, so one instance serves any baud rate without resynthesis.
- Sits between a bus-side peripheral register and the tx pin.

---
 rtl/uart_tx_cfg_if.sv | 12 +
 rtl/uart_tx_cfg.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Bus-side write channel of the configurable UART transmitter.
// A word transfers on a rising edge where valid_tx && ready_tx; ready_tx never depends on valid_tx.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_tx;
  logic                  valid_tx;
  logic                  ready_tx;

  modport master (output data_tx, output valid_tx, input ready_tx);
  modport slave  (input data_tx, input valid_tx, output ready_tx);
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: word FIFO feeding a start/data/parity/stop serialiser
// whose bit period, parity and stop count are captured per frame when a word is popped.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_cfg_if.slave         bus,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 sig_tx,
  output logic                 busy,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [2:0]           state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  stop2_q, stop2_d;
  logic                  sig_q, sig_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  ready;
  logic                  push;
  logic                  pop;
  logic                  start_frame;
  logic                  bit_done;
  logic                  fifo_nonempty;
  logic [DATA_WIDTH-1:0] head;
  logic [DIV_WIDTH-1:0]  div_in;

  assign ready         = (level_q != LVL_W'(FIFO_DEPTH));
  assign push          = bus.valid_tx && ready;
  assign fifo_nonempty = (level_q != '0);
  assign head          = mem_q[rd_ptr_q];
  assign div_in        = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
  assign bit_done      = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    two_stop_d  = two_stop_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    stop2_d     = stop2_q;
    sig_d       = sig_q;
    start_frame = 1'b0;

    if (state_q != S_IDLE && !bit_done) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) start_frame = 1'b1;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          sig_d   = shift_q[0];
          bit_d   = '0;
          cnt_d   = div_q - DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = div_q - DIV_WIDTH'(1);
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              sig_d   = par_bit_q;
            end else begin
              state_d = S_STOP;
              sig_d   = 1'b1;
              stop2_d = 1'b0;
            end
          end else begin
            // shift_q[0] always holds the bit currently on the line
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            sig_d   = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          sig_d   = 1'b1;
          stop2_d = 1'b0;
          cnt_d   = div_q - DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
            cnt_d   = div_q - DIV_WIDTH'(1);
          end else if (fifo_nonempty) begin
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sig_d   = 1'b1;
      end
    endcase

    // Config is sampled only here, so mid-frame changes wait for the next pop
    if (start_frame) begin
      state_d    = S_START;
      sig_d      = 1'b0;
      shift_d    = head;
      par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_bit_d  = (parity_mode == 2'b10) ? ~^head : ^head;
      two_stop_d = two_stop;
      div_d      = div_in;
      cnt_d      = div_in - DIV_WIDTH'(1);
      bit_d      = '0;
      stop2_d    = 1'b0;
    end
  end

  assign pop = start_frame;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      div_q      <= DIV_WIDTH'(2);
      cnt_q      <= '0;
      bit_q      <= '0;
      stop2_q    <= 1'b0;
      sig_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop2_q    <= stop2_d;
      sig_q      <= sig_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset: level/pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_tx;
  end

  assign bus.ready_tx = ready;
  assign sig_tx       = sig_q;
  assign busy         = (state_q != S_IDLE) || fifo_nonempty;
  assign fifo_level   = level_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: table vectors, hand-written corner sequences and random frames,
// with the line waveform compared against a frame model built from the bit-level rules.
module tb_uart_tx_cfg;
  localparam int DW    = 8;
  localparam int DIVW  = 16;
  localparam int DEPTH = 4;
  localparam int LVLW  = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [DIVW-1:0] baud_div;
  logic [1:0]      parity_mode;
  logic            two_stop;
  logic            sig_tx;
  logic            busy;
  logic [LVLW-1:0] fifo_level;
  logic [2:0]      state_dbg;

  uart_tx_cfg_if #(.DATA_WIDTH(DW)) bus_if ();

  uart_tx_cfg #(.DATA_WIDTH(DW), .DIV_WIDTH(DIVW), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .sig_tx      (sig_tx),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int         n_pass = 0;
  int         n_total = 0;
  logic       rec_on = 1'b0;
  logic [0:0] line_q[$];
  logic [0:0] exp_q[$];

  always @(posedge clk) begin
    #2;
    if (rec_on) line_q.push_back(sig_tx);
  end

  typedef struct {
    logic [7:0] data;
    int         div;
    int         pm;
    int         ts;
    int         has_par;
    int         exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_cfg(input int div, input int pm, input int ts);
    baud_div    = DIVW'(div);
    parity_mode = 2'(pm);
    two_stop    = 1'(ts);
  endtask

  task automatic push_word(input logic [7:0] w);
    int guard;
    guard = 0;
    bus_if.data_tx  = w;
    bus_if.valid_tx = 1'b1;
    while (!bus_if.ready_tx && guard < 2000) begin
      tick();
      guard++;
    end
    chk("push_ready", bus_if.ready_tx, 1);
    tick();
    bus_if.valid_tx = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int g;
    g = 0;
    while (busy && g < max_cyc) begin
      tick();
      g++;
    end
    chk(name, busy, 0);
  endtask

  task automatic start_rec();
    line_q.delete();
    exp_q.delete();
    rec_on = 1'b1;
  endtask

  task automatic stop_rec();
    rec_on = 1'b0;
    while (line_q.size() > 0 && line_q[0] == 1'b1) void'(line_q.pop_front());
  endtask

  // Reference model: expected line level for every clock of one frame
  task automatic add_frame(input logic [7:0] w, input int div, input int pm, input int ts);
    int         d;
    int         ones;
    logic [0:0] bits[$];
    d    = (div < 2) ? 2 : div;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (pm == 1) bits.push_back(1'((ones % 2)));
    if (pm == 2) bits.push_back(1'((1 - ones % 2)));
    for (int s = 0; s < 1 + ts; s++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < d; c++) exp_q.push_back(bits[i]);
    end
  endtask

  task automatic compare_wave(input string name);
    int bad;
    int n;
    bad = -1;
    n = (line_q.size() < exp_q.size()) ? line_q.size() : exp_q.size();
    chk({name, "_len"}, line_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      if (bad < 0 && line_q[i] != exp_q[i]) bad = i;
    end
    chk({name, "_first_bad_cycle"}, bad, -1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] words[7];
    int         k;
    int         lows;
    int         d;
    logic       r;

    rst             = 1'b1;
    bus_if.data_tx  = '0;
    bus_if.valid_tx = 1'b0;
    set_cfg(4, 0, 0);
    tick();
    tick();
    chk("rst_sig_tx", sig_tx, 1);
    chk("rst_ready", bus_if.ready_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    rst = 1'b0;
    tick();

    // Table: single frames with known length and parity bit
    vecs[0] = '{8'hA5, 4, 0, 0, 0, 0, 40};
    vecs[1] = '{8'hA5, 3, 1, 0, 1, 0, 33};
    vecs[2] = '{8'h07, 3, 2, 0, 1, 0, 33};
    vecs[3] = '{8'h00, 3, 2, 0, 1, 1, 33};
    vecs[4] = '{8'h3C, 1, 3, 1, 0, 0, 22};
    for (int v = 0; v < 5; v++) begin
      set_cfg(vecs[v].div, vecs[v].pm, vecs[v].ts);
      start_rec();
      push_word(vecs[v].data);
      chk($sformatf("v%0d_line_high_at_accept", v), sig_tx, 1);
      tick();
      chk($sformatf("v%0d_start_one_clk_after", v), sig_tx, 0);
      wait_idle(2000, $sformatf("v%0d_idle", v));
      stop_rec();
      chk($sformatf("v%0d_frame_len", v), line_q.size(), vecs[v].exp_len);
      d = (vecs[v].div < 2) ? 2 : vecs[v].div;
      if (vecs[v].has_par != 0 && line_q.size() > d * (1 + DW))
        chk($sformatf("v%0d_parity", v), line_q[d * (1 + DW)], vecs[v].exp_par);
      add_frame(vecs[v].data, vecs[v].div, vecs[v].pm, vecs[v].ts);
      compare_wave($sformatf("v%0d_wave", v));
      tick();
    end

    // Back-to-back two-stop frames: no idle gap between them
    set_cfg(2, 0, 1);
    start_rec();
    push_word(8'h55);
    push_word(8'hAA);
    wait_idle(2000, "b2b_idle");
    stop_rec();
    chk("b2b_total_len", line_q.size(), 44);
    add_frame(8'h55, 2, 0, 1);
    add_frame(8'hAA, 2, 0, 1);
    compare_wave("b2b_wave");
    tick();

    // Hold valid_tx against a full FIFO
    set_cfg(10, 0, 0);
    for (int i = 0; i < 7; i++) words[i] = 8'($urandom_range(0, 255));
    start_rec();
    k = 0;
    bus_if.valid_tx = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus_if.data_tx = words[k];
      r = bus_if.ready_tx;
      tick();
      if (r && k < 6) k++;
    end
    chk("full_accepted", k, 5);
    chk("full_ready", bus_if.ready_tx, 0);
    chk("full_level", fifo_level, 4);
    bus_if.valid_tx = 1'b0;
    wait_idle(2000, "full_idle");
    stop_rec();
    for (int i = 0; i < 5; i++) add_frame(words[i], 10, 0, 0);
    compare_wave("full_wave");
    tick();

    // baud_div change mid-frame only affects the following frame
    set_cfg(4, 0, 0);
    start_rec();
    push_word(8'h96);
    push_word(8'h3B);
    repeat (10) tick();
    baud_div = DIVW'(8);
    wait_idle(2000, "baud_chg_idle");
    stop_rec();
    add_frame(8'h96, 4, 0, 0);
    add_frame(8'h3B, 8, 0, 0);
    compare_wave("baud_chg_wave");
    tick();

    // Reset during data bit 3 with two words queued
    set_cfg(4, 0, 0);
    push_word(8'hF0);
    push_word(8'h11);
    push_word(8'h22);
    repeat (16) tick();
    chk("pre_rst_level", fifo_level, 2);
    chk("pre_rst_bit3", sig_tx, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_sig_tx", sig_tx, 1);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ready", bus_if.ready_tx, 1);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    lows = 0;
    repeat (200) begin
      tick();
      if (!sig_tx) lows++;
    end
    chk("post_rst_no_frames", lows, 0);
    chk("post_rst_busy", busy, 0);

    // Random single frames, including divisors below the minimum
    for (int t = 0; t < 6; t++) begin
      int         rd, rp, rs;
      logic [7:0] rw;
      rd = $urandom_range(0, 5);
      rp = $urandom_range(0, 3);
      rs = $urandom_range(0, 1);
      rw = 8'($urandom_range(0, 255));
      set_cfg(rd, rp, rs);
      start_rec();
      push_word(rw);
      wait_idle(2000, $sformatf("rnd%0d_idle", t));
      stop_rec();
      add_frame(rw, rd, rp, rs);
      compare_wave($sformatf("rnd%0d_wave", t));
      tick();
    end

    // Random bursts of three words under one held config
    for (int t = 0; t < 3; t++) begin
      int         rd, rp, rs;
      logic [7:0] bw[3];
      rd = $urandom_range(2, 6);
      rp = $urandom_range(0, 3);
      rs = $urandom_range(0, 1);
      set_cfg(rd, rp, rs);
      start_rec();
      for (int i = 0; i < 3; i++) begin
        bw[i] = 8'($urandom_range(0, 255));
        push_word(bw[i]);
      end
      wait_idle(3000, $sformatf("burst%0d_idle", t));
      stop_rec();
      for (int i = 0; i < 3; i++) add_frame(bw[i], rd, rp, rs);
      compare_wave($sformatf("burst%0d_wave", t));
      tick();
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
